fifo_ptr_counter: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_wrap_ptr.sv | 28 ++
 rtl/fifo_ptr_counter.sv | 64 ++++++
 tb/tb_fifo_ptr_counter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO pointer controller and the FIFO memory.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 4;

  // Index width for a depth-entry array; at least 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-depth pointer register: advances on inc, wraps from depth-1 to 0.
// Latency: ptr updates one cycle after inc is sampled high.
// Backpressure: none; the caller qualifies inc.
// Ports: clk, rst (async active-low), inc (advance request), ptr (current index).
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int depth = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  output logic [ptr_width(depth)-1:0] ptr
);

  localparam int             PW   = ptr_width(depth);
  localparam logic [PW-1:0]  LAST = PW'(depth - 1);

  // Explicit compare against depth-1 so non-power-of-two depths wrap correctly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_ptr_counter.sv
// Write/read pointer and occupancy controller sitting beside a FIFO storage array.
// Latency: pointers, count and flags update one cycle after push/pop are sampled.
// Backpressure: push while full and pop while empty are silently dropped.
// Ports: clk, rst (async active-low), push, pop, full, pndng,
//        pointer_in (next write slot), pointer_out (oldest unread slot).
module fifo_ptr_counter
  import fifo_pkg::*;
#(
  parameter int depth = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  output logic                        full,
  output logic                        pndng,
  output logic [ptr_width(depth)-1:0] pointer_in,
  output logic [ptr_width(depth)-1:0] pointer_out
);

  localparam int            CW     = cnt_width(depth);
  localparam logic [CW-1:0] CNT_FULL = CW'(depth);

  // Occupancy, 0..depth. Name is kept stable for hierarchical probing.
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  // Qualification uses the registered flags, so full+push+pop takes only the
  // pop and empty+push+pop takes only the push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & pndng;

  fifo_wrap_ptr #(.depth(depth)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (pointer_in)
  );

  fifo_wrap_ptr #(.depth(depth)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (pointer_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flags decode straight from the registered count; no extra stage.
  assign full  = (count == CNT_FULL);
  assign pndng = (count != '0);

endmodule

// File: tb/tb_fifo_ptr_counter.sv
// Self-checking bench for fifo_ptr_counter (depth 4) against a transaction-count model.
// Latency: checks one cycle after each request edge.
// Backpressure: model drops push when full and pop when empty.
module tb_fifo_ptr_counter;
  import fifo_pkg::*;

  localparam int D  = 4;
  localparam int PW = ptr_width(D);
  localparam int CW = cnt_width(D);
  localparam int VW = 2 * PW + CW + 2;

  logic          clk_tb;
  logic          rst;
  logic          push;
  logic          pop;
  logic          full;
  logic          pndng;
  logic [PW-1:0] pointer_in;
  logic [PW-1:0] pointer_out;

  int checks;
  int errors;

  // Model: total accepted pushes and pops since reset.
  int n_push;
  int n_pop;

  fifo_ptr_counter #(.depth(D)) dut (
    .clk         (clk_tb),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .full        (full),
    .pndng       (pndng),
    .pointer_in  (pointer_in),
    .pointer_out (pointer_out)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  function automatic logic [VW-1:0] exp_vec();
    int occ;
    occ = n_push - n_pop;
    return {PW'(n_push % D), PW'(n_pop % D), CW'(occ), (occ == D), (occ != 0)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {pointer_in, pointer_out, dut.count, full, pndng};
  endfunction

  // Drive one request cycle and advance the model; caller compares afterwards.
  task automatic step(input logic p, input logic q);
    int occ;
    occ  = n_push - n_pop;
    push = p;
    pop  = q;
    if (p && occ < D) n_push++;
    if (q && occ > 0) n_pop++;
    @(posedge clk_tb);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk_tb);
    #1;
    rst    = 1'b1;
    n_push = 0;
    n_pop  = 0;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      push = i[0];
      pop  = ~i[0];
      @(posedge clk_tb);
      #1;
      checks++;
      if (dut_vec() !== '0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected all zero", i, dut_vec());
      end
    end
    push = 1'b0;
    pop  = 1'b0;
    rst  = 1'b1;
    n_push = 0;
    n_pop  = 0;
    step(1'b1, 1'b0);
    checks++;
    if (pointer_in !== PW'(1) || dut.count !== CW'(1) || pndng !== 1'b1) begin
      errors++;
      $display("FAIL first_push: got pin=%0d count=%0d pndng=%b expected 1 1 1",
               pointer_in, dut.count, pndng);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < D + 1; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fill[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (full !== 1'b1 || pointer_in !== '0 || dut.count !== CW'(D)) begin
      errors++;
      $display("FAIL fill_end: got full=%b pin=%0d count=%0d expected 1 0 4",
               full, pointer_in, dut.count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < D + 1; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drain[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (pndng !== 1'b0 || pointer_out !== '0 || dut.count !== '0) begin
      errors++;
      $display("FAIL drain_end: got pndng=%b pout=%0d count=%0d expected 0 0 0",
               pndng, pointer_out, dut.count);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (pointer_in !== PW'(3) || pointer_out !== PW'(1) || dut.count !== CW'(2) ||
        full !== 1'b0 || pndng !== 1'b1) begin
      errors++;
      $display("FAIL simul_mid: got %b expected pin=3 pout=1 count=2 full=0 pndng=1", dut_vec());
    end
  endtask

  task automatic test_boundary();
    do_reset();
    step(1'b1, 1'b1);
    checks++;
    if (dut.count !== CW'(1) || pointer_out !== '0 || pointer_in !== PW'(1)) begin
      errors++;
      $display("FAIL empty_pushpop: got count=%0d pout=%0d pin=%0d expected 1 0 1",
               dut.count, pointer_out, pointer_in);
    end
    for (int i = 0; i < D - 1; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (dut.count !== CW'(D - 1) || pointer_in !== '0 || pointer_out !== PW'(1)) begin
      errors++;
      $display("FAIL full_pushpop: got count=%0d pin=%0d pout=%0d expected 3 0 1",
               dut.count, pointer_in, pointer_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b expected all zero before any edge", dut_vec());
    end
    @(posedge clk_tb);
    #1;
    rst    = 1'b1;
    n_push = 0;
    n_pop  = 0;
  endtask

  task automatic test_random();
    int occ;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      end
      occ = n_push - n_pop;
      if (occ < 0 || occ > D) begin
        errors++;
        $display("FAIL random_model_range[%0d]: occupancy %0d outside 0..%0d", i, occ, D);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_push = 0;
    n_pop  = 0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_boundary();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
